// File: rtl/dlx_execute_unit.sv
// DLX execute unit: registered operand/decode stage feeding a registered
// ALU/shifter stage, plus the store-data path toward data memory.
module dlx_execute_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_ex,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] imm,
  input  logic [31:0] mem_read,
  input  logic [6:0]  cntrl_in,
  output logic [31:0] aluout,
  output logic        carry,
  output logic        mem_wr_en,
  output logic [31:0] mem_write_out
);

  localparam logic [2:0] CL_ARITH = 3'b000;
  localparam logic [2:0] CL_SHIFT = 3'b001;
  localparam logic [2:0] CL_LOAD  = 3'b010;
  localparam logic [2:0] CL_STORE = 3'b011;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic [31:0] aluin1_q, aluin1_d;
  logic [31:0] aluin2_q, aluin2_d;
  logic [2:0]  opsel_q, opsel_d;
  logic [4:0]  shift_nos_q, shift_nos_d;
  logic        en_ar_q, en_ar_d;
  logic        en_sh_q, en_sh_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic [31:0] mem_write_out_q, mem_write_out_d;
  logic [31:0] aluout_q, aluout_d;
  logic        carry_q, carry_d;

  logic [31:0] opb;
  assign opb = cntrl_in[3] ? imm : src2;

  always_comb begin
    aluin1_d        = aluin1_q;
    aluin2_d        = aluin2_q;
    opsel_d         = opsel_q;
    shift_nos_d     = shift_nos_q;
    mem_write_out_d = mem_write_out_q;
    en_ar_d         = 1'b0;
    en_sh_d         = 1'b0;
    mem_wr_en_d     = 1'b0;
    if (en_ex) begin
      case (cntrl_in[6:4])
        CL_ARITH: begin
          aluin1_d = src1;
          aluin2_d = opb;
          opsel_d  = cntrl_in[2:0];
          en_ar_d  = 1'b1;
        end
        CL_SHIFT: begin
          aluin1_d    = src1;
          aluin2_d    = opb;
          shift_nos_d = opb[4:0];
          opsel_d     = cntrl_in[2:0];
          en_sh_d     = 1'b1;
        end
        CL_LOAD: begin
          aluin1_d = mem_read;
          aluin2_d = 32'd0;
          opsel_d  = OP_ADD;
          en_ar_d  = 1'b1;
        end
        CL_STORE: begin
          aluin1_d        = src1;
          aluin2_d        = imm;
          opsel_d         = OP_ADD;
          en_ar_d         = 1'b1;
          mem_wr_en_d     = 1'b1;
          mem_write_out_d = src2;
        end
        default: ;
      endcase
    end
  end

  logic [32:0] sum33, dif33;
  logic        slt;
  logic [31:0] ar_res;
  logic        ar_c;

  assign sum33 = {1'b0, aluin1_q} + {1'b0, aluin2_q};
  assign dif33 = {1'b0, aluin1_q} - {1'b0, aluin2_q};
  assign slt   = $signed(aluin1_q) < $signed(aluin2_q);

  always_comb begin
    ar_res = 32'd0;
    ar_c   = 1'b0;
    unique case (opsel_q)
      OP_ADD:  begin ar_res = sum33[31:0]; ar_c = sum33[32]; end
      OP_SUB:  begin ar_res = dif33[31:0]; ar_c = dif33[32]; end
      OP_NOT:  ar_res = ~aluin1_q;
      OP_AND:  ar_res = aluin1_q & aluin2_q;
      OP_OR:   ar_res = aluin1_q | aluin2_q;
      OP_XOR:  ar_res = aluin1_q ^ aluin2_q;
      OP_SLT:  ar_res = {31'd0, slt};
      OP_PASS: ar_res = aluin2_q;
    endcase
  end

  // Extra guard bit on each side captures the last bit shifted out.
  logic [32:0]        shl_x, shr_x;
  logic signed [32:0] sra_x;
  logic [63:0]        rol_x, ror_x;
  logic [31:0]        sh_res;
  logic               sh_c;

  assign shl_x = {1'b0, aluin1_q} << shift_nos_q;
  assign shr_x = {aluin1_q, 1'b0} >> shift_nos_q;
  assign sra_x = $signed({aluin1_q, 1'b0}) >>> shift_nos_q;
  assign rol_x = {aluin1_q, aluin1_q} << shift_nos_q;
  assign ror_x = {aluin1_q, aluin1_q} >> shift_nos_q;

  always_comb begin
    sh_res = aluin1_q;
    sh_c   = 1'b0;
    unique case (opsel_q)
      3'd0, 3'd1: begin sh_res = shl_x[31:0]; sh_c = shl_x[32]; end
      3'd2:       begin sh_res = shr_x[32:1]; sh_c = shr_x[0]; end
      3'd3:       begin sh_res = sra_x[32:1]; sh_c = sra_x[0]; end
      3'd4:       sh_res = rol_x[63:32];
      3'd5:       sh_res = ror_x[31:0];
      3'd6, 3'd7: sh_res = aluin1_q;
    endcase
  end

  always_comb begin
    aluout_d = aluout_q;
    carry_d  = carry_q;
    if (en_ar_q) begin
      aluout_d = ar_res;
      carry_d  = ar_c;
    end else if (en_sh_q) begin
      aluout_d = sh_res;
      carry_d  = sh_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluin1_q        <= 32'd0;
      aluin2_q        <= 32'd0;
      opsel_q         <= 3'd0;
      shift_nos_q     <= 5'd0;
      en_ar_q         <= 1'b0;
      en_sh_q         <= 1'b0;
      mem_wr_en_q     <= 1'b0;
      mem_write_out_q <= 32'd0;
      aluout_q        <= 32'd0;
      carry_q         <= 1'b0;
    end else begin
      aluin1_q        <= aluin1_d;
      aluin2_q        <= aluin2_d;
      opsel_q         <= opsel_d;
      shift_nos_q     <= shift_nos_d;
      en_ar_q         <= en_ar_d;
      en_sh_q         <= en_sh_d;
      mem_wr_en_q     <= mem_wr_en_d;
      mem_write_out_q <= mem_write_out_d;
      aluout_q        <= aluout_d;
      carry_q         <= carry_d;
    end
  end

  assign aluout        = aluout_q;
  assign carry         = carry_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign mem_write_out = mem_write_out_q;

endmodule

// File: tb/tb_dlx_execute_unit.sv
// Directed bench for dlx_execute_unit with hand-computed expectations.
module tb_dlx_execute_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_ex;
  logic [31:0] src1, src2, imm, mem_read;
  logic [6:0]  cntrl_in;
  logic [31:0] aluout;
  logic        carry;
  logic        mem_wr_en;
  logic [31:0] mem_write_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dlx_execute_unit dut (
    .clk(clk),
    .rst(rst),
    .en_ex(en_ex),
    .src1(src1),
    .src2(src2),
    .imm(imm),
    .mem_read(mem_read),
    .cntrl_in(cntrl_in),
    .aluout(aluout),
    .carry(carry),
    .mem_wr_en(mem_wr_en),
    .mem_write_out(mem_write_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction for a single edge, then drop en_ex.
  task automatic issue(input logic [6:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] i,
                       input logic [31:0] m);
    @(negedge clk);
    cntrl_in = c;
    src1     = a;
    src2     = b;
    imm      = i;
    mem_read = m;
    en_ex    = 1'b1;
    step();
    en_ex    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en_ex = 1'b0;
    src1 = '0;
    src2 = '0;
    imm = '0;
    mem_read = '0;
    cntrl_in = '0;
    repeat (2) step();
    chk("rst_aluout", aluout, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_wdata", mem_write_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(7'b000_0_000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    step();
    chk("add_res", aluout, 32'd0);
    chk("add_c", {31'd0, carry}, 32'd1);

    issue(7'b000_1_001, 32'd5, 32'd100, 32'd7, 32'd0);
    step();
    chk("sub_res", aluout, 32'hFFFF_FFFE);
    chk("sub_c", {31'd0, carry}, 32'd1);

    issue(7'b001_0_011, 32'h8000_0010, 32'd4, 32'd0, 32'd0);
    step();
    chk("sra_res", aluout, 32'hF800_0001);
    chk("sra_c", {31'd0, carry}, 32'd0);

    issue(7'b000_0_110, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    step();
    chk("slt_res", aluout, 32'd1);
    chk("slt_c", {31'd0, carry}, 32'd0);

    issue(7'b000_0_101, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 32'd0);
    step();
    chk("xor_res", aluout, 32'h5A5A_A5A5);

    issue(7'b001_1_000, 32'h8000_0001, 32'd0, 32'd1, 32'd0);
    step();
    chk("shl_res", aluout, 32'h0000_0002);
    chk("shl_c", {31'd0, carry}, 32'd1);

    issue(7'b001_0_010, 32'd3, 32'd1, 32'd0, 32'd0);
    step();
    chk("shr_res", aluout, 32'd1);
    chk("shr_c", {31'd0, carry}, 32'd1);

    issue(7'b001_0_000, 32'h1234_5678, 32'd0, 32'd0, 32'd0);
    step();
    chk("shl0_res", aluout, 32'h1234_5678);
    chk("shl0_c", {31'd0, carry}, 32'd0);

    issue(7'b001_0_101, 32'd1, 32'd1, 32'd0, 32'd0);
    step();
    chk("ror_res", aluout, 32'h8000_0000);
    chk("ror_c", {31'd0, carry}, 32'd0);

    issue(7'b011_0_000, 32'h100, 32'hDEAD_BEEF, 32'd8, 32'd0);
    chk("st_wr_en1", {31'd0, mem_wr_en}, 32'd1);
    chk("st_wdata", mem_write_out, 32'hDEAD_BEEF);
    step();
    chk("st_addr", aluout, 32'h108);
    chk("st_wr_en2", {31'd0, mem_wr_en}, 32'd0);
    step();
    chk("st_hold", aluout, 32'h108);
    chk("st_wdata_hold", mem_write_out, 32'hDEAD_BEEF);

    issue(7'b010_0_000, 32'd9, 32'd9, 32'd9, 32'h1234_5678);
    chk("ld_wr_en", {31'd0, mem_wr_en}, 32'd0);
    step();
    chk("ld_res", aluout, 32'h1234_5678);
    chk("ld_c", {31'd0, carry}, 32'd0);
    issue(7'b111_0_000, 32'd1, 32'd2, 32'd3, 32'd4);
    step();
    chk("nop_hold", aluout, 32'h1234_5678);
    chk("nop_c", {31'd0, carry}, 32'd0);

    // back-to-back issue with no bubble
    @(negedge clk);
    cntrl_in = 7'b000_0_000;
    src1 = 32'd1;
    src2 = 32'd2;
    en_ex = 1'b1;
    step();
    @(negedge clk);
    cntrl_in = 7'b000_0_100;
    src1 = 32'h0000_00F0;
    src2 = 32'h0000_000F;
    step();
    en_ex = 1'b0;
    chk("pipe_add", aluout, 32'd3);
    step();
    chk("pipe_or", aluout, 32'h0000_00FF);

    issue(7'b011_0_000, 32'h200, 32'hCAFE_0000, 32'd4, 32'd0);
    chk("mid_wr_en", {31'd0, mem_wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr", {31'd0, mem_wr_en}, 32'd0);
    chk("mid_rst_wd", mem_write_out, 32'd0);
    chk("mid_rst_out", aluout, 32'd0);
    step();
    chk("mid_rst_out2", aluout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_out", aluout, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dlx_execute_unit.md
# dlx_execute_unit

Two-stage DLX execute unit. A registered preprocessing stage decodes a 7-bit control word and selects operands. A registered ALU stage holds arithmetic/logic and shift datapaths and produces a 32-bit result with carry. It sits between instruction decode/register fetch and the memory/writeback stages, and also drives the store-data path to data memory.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- en_ex  in  1  execute enable; the instruction on the inputs is accepted when 1.
- src1  in  32  register operand A.
- src2  in  32  register operand B; also the store data.
- imm  in  32  sign-extended immediate.
- mem_read  in  32  load data returned from data memory.
- cntrl_in  in  7  control word: [6:4] op class, [3] imm_sel, [2:0] opsel.
- aluout  out  32  registered ALU result.
- carry  out  1  registered carry/borrow/shift-out flag.
- mem_wr_en  out  1  registered store strobe.
- mem_write_out  out  32  registered store data.

## Operation
- Op classes (cntrl_in[6:4]):
  - 000 arithmetic/logic.
  - 001 shift.
  - 010 load.
  - 011 store.
  - 100–111 NOP.
- Operand B = imm when cntrl_in[3]=1, else src2.
- Stage 1 registers, all loaded only when en_ex=1: aluin1, aluin2, op, opsel, shift_nos, en_ar, en_sh, mem_wr_en, mem_write_out.
- Stage 1 decode per class:
  - Arithmetic: aluin1=src1, aluin2=B, opsel=cntrl_in[2:0], en_ar=1.
  - Shift: aluin1=src1, shift_nos=B[4:0], opsel=cntrl_in[2:0], en_sh=1.
  - Load: aluin1=mem_read, aluin2=0, opsel=ADD, en_ar=1.
  - Store: aluin1=src1, aluin2=imm (address), opsel=ADD, en_ar=1, mem_wr_en=1, mem_write_out=src2.
  - NOP: en_ar=en_sh=mem_wr_en=0.
- mem_wr_en is 0 for every class except store.
- When en_ex=0: en_ar, en_sh and mem_wr_en are cleared to 0; all data registers hold.
- Arithmetic opsel:
  - 000 ADD: carry = bit-32 carry-out.
  - 001 SUB (A−B): carry = 1 on borrow (A<B unsigned).
  - 010 NOT A.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 SLT signed: result = 1 or 0.
  - 111 pass B.
  - carry = 0 for every opsel except ADD and SUB.
- Shift opsel:
  - 000 and 001 logical left.
  - 010 logical right.
  - 011 arithmetic right.
  - 100 rotate left.
  - 101 rotate right.
  - 110 and 111 pass A.
  - carry = last bit shifted out; carry = 0 when shift_nos=0 and for rotate and pass.
- Stage 2 updates aluout/carry from the arithmetic unit when en_ar=1, or from the shifter when en_sh=1.
- en_ar and en_sh are never both 1.
- With neither enable set, aluout and carry hold.
- All arithmetic is modulo 2^32 and unsigned except SLT and arithmetic right shift.

## Timing
- Reset (async, active-high): every stage-1 and stage-2 register is 0, so aluout=0, carry=0, mem_wr_en=0, mem_write_out=0. Values stay 0 until the first enabled edge after rst falls.
- Latency, edges counted from the edge that samples an instruction with en_ex=1 (edge 1):
  - mem_wr_en and mem_write_out are valid after edge 1.
  - aluout and carry are valid after edge 2.
- Throughput: one instruction per cycle; back-to-back instructions pipeline with no bubbles.
- en_ex low for one cycle:
  - The next edge clears en_ar, en_sh and mem_wr_en.
  - The result already in flight still lands at the following edge.
  - After that, aluout holds.
- Reset mid-operation discards both stages immediately, with no partial results.
- There is no handshake or backpressure.

## Test plan
- Reset: assert rst for 1 cycle -> aluout=0, carry=0, mem_wr_en=0, mem_write_out=0.
- ADD with carry: cntrl_in=7'b000_0_000, src1=32'hFFFF_FFFF, src2=1, en_ex=1 -> after 2 edges aluout=0, carry=1.
- SUB with immediate: cntrl_in=7'b000_1_001, src1=5, imm=7 -> aluout=32'hFFFF_FFFE, carry=1.
- Arithmetic right shift: cntrl_in=7'b001_0_011, src1=32'h8000_0010, src2=4 -> aluout=32'hF800_0001, carry=0.
- Store then hold: cntrl_in=7'b011_0_000, src1=32'h100, imm=8, src2=32'hDEAD_BEEF -> after 1 edge mem_wr_en=1 and mem_write_out=32'hDEAD_BEEF; after 2 edges aluout=32'h108. Then set en_ex=0 -> mem_wr_en=0 on the next edge, and aluout holds 32'h108.
- Load then NOP: cntrl_in=7'b010_0_000, mem_read=32'h1234_5678 -> aluout=32'h1234_5678, carry=0. Next issue cntrl_in=7'b111_0_000 -> aluout unchanged.
